song_slot_recorder: RTL and testbench

//  Multi-slot record/playback memory for the organ: captures the note/octave code at a

---
 rtl/song_slot_recorder_pkg.sv | 15 +
 rtl/song_slot_recorder_ram.sv | 29 ++
 rtl/song_slot_recorder.sv | 180 ++++++++++++++++++
 tb/tb_song_slot_recorder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/song_slot_recorder_pkg.sv
// rtl/song_slot_recorder_pkg.sv - shared defaults and state encoding for the song slot recorder
package song_slot_recorder_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 256;
  localparam int DEF_SLOTS  = 4;
  localparam int DEF_CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

endpackage

// File: rtl/song_slot_recorder_ram.sv
// rtl/song_slot_recorder_ram.sv - single-port-write, synchronous-read note memory for all slots
module music_sp_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write port; contents are deliberately left uninitialised on reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read that holds its value until the next read strobe.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/song_slot_recorder.sv
// rtl/song_slot_recorder.sv - multi-slot note record/playback controller
module song_slot_recorder
  import song_slot_recorder_pkg::*;
#(
  parameter int   DATA_W = DEF_DATA_W,
  parameter int   DEPTH  = DEF_DEPTH,
  parameter int   SLOTS  = DEF_SLOTS,
  parameter int   CNT_W  = DEF_CNT_W,
  localparam int  ADDR_W = $clog2(DEPTH),
  localparam int  SLOT_W = $clog2(SLOTS),
  localparam int  LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SLOT_W-1:0] slot_sel,
  input  logic [CNT_W-1:0]  interval,
  input  logic              rec_start,
  input  logic              rec_stop,
  input  logic              play_start,
  input  logic              play_stop,
  input  logic              loop_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              rec_busy,
  output logic              play_busy,
  output logic              full,
  output logic              done,
  output logic [LEN_W-1:0]  slot_len
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0]  LEN_FULL = LEN_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_t                    state, state_nxt;
  logic [SLOT_W-1:0]         slot_r;
  logic [CNT_W-1:0]          intv_r;
  logic [CNT_W-1:0]          tick;
  logic [ADDR_W-1:0]         ptr;
  logic [LEN_W-1:0]          len_tab [SLOTS];

  logic [LEN_W-1:0]          len_cur;
  logic [ADDR_W-1:0]         ptr_inc;
  logic                      sample;
  logic                      last_play;

  logic                      enter_rec, enter_play, empty_play;
  logic                      rec_full, ptr_step, ptr_wrap, finish;
  logic                      ram_we, ram_re;
  logic [SLOT_W+ADDR_W-1:0]  ram_raddr;

  assign len_cur   = len_tab[slot_r];
  assign slot_len  = len_tab[slot_sel];
  assign ptr_inc   = ptr + PTR_ONE;
  assign sample    = (state != ST_IDLE) && (tick == intv_r);
  // Compare ptr+1 against the length so an empty length never underflows.
  assign last_play = (({1'b0, ptr} + LEN_ONE) == len_cur);
  assign finish    = (state != ST_IDLE) && (state_nxt == ST_IDLE);
  assign rec_busy  = (state == ST_REC);
  assign play_busy = (state == ST_PLAY);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and per-cycle memory/pointer strobes.
  always_comb begin
    state_nxt  = state;
    enter_rec  = 1'b0;
    enter_play = 1'b0;
    empty_play = 1'b0;
    rec_full   = 1'b0;
    ptr_step   = 1'b0;
    ptr_wrap   = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_raddr  = {slot_r, ptr};
    case (state)
      ST_IDLE: begin
        if (rec_start) begin
          enter_rec = 1'b1;
          state_nxt = ST_REC;
        end else if (play_start) begin
          if (slot_len == '0) begin
            empty_play = 1'b1;
          end else begin
            enter_play = 1'b1;
            state_nxt  = ST_PLAY;
            ram_re     = 1'b1;
            ram_raddr  = {slot_sel, {ADDR_W{1'b0}}};
          end
        end
      end
      ST_REC: begin
        if (sample) begin
          ram_we   = 1'b1;
          ptr_step = 1'b1;
          if ((len_cur + LEN_ONE) == LEN_FULL) begin
            rec_full  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        if (rec_stop) state_nxt = ST_IDLE;
      end
      ST_PLAY: begin
        if (play_stop) begin
          state_nxt = ST_IDLE;
        end else if (sample) begin
          if (last_play) begin
            if (loop_en) begin
              ptr_wrap  = 1'b1;
              ram_re    = 1'b1;
              ram_raddr = {slot_r, {ADDR_W{1'b0}}};
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            ptr_step  = 1'b1;
            ram_re    = 1'b1;
            ram_raddr = {slot_r, ptr_inc};
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: slot/interval latch, sample tick, pointer, length table and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_r    <= '0;
      intv_r    <= CNT_ONE;
      tick      <= CNT_ONE;
      ptr       <= '0;
      full      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < SLOTS; i++) len_tab[i] <= '0;
    end else begin
      done <= finish | empty_play;
      if (enter_rec || enter_play) begin
        slot_r <= slot_sel;
        intv_r <= (interval == '0) ? CNT_ONE : interval;
        tick   <= CNT_ONE;
        ptr    <= '0;
      end else if (state != ST_IDLE) begin
        tick <= sample ? CNT_ONE : tick + CNT_ONE;
        if (ptr_wrap)      ptr <= '0;
        else if (ptr_step) ptr <= ptr_inc;
      end
      if (enter_rec) begin
        len_tab[slot_sel] <= '0;
        full              <= 1'b0;
      end
      if (ram_we)   len_tab[slot_r] <= len_cur + LEN_ONE;
      if (rec_full) full <= 1'b1;
      if (enter_play)                          out_valid <= 1'b1;
      else if ((state == ST_PLAY) && finish)   out_valid <= 1'b0;
    end
  end

  music_sp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (SLOT_W + ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr ({slot_r, ptr}),
    .wdata (data_in),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_song_slot_recorder.sv
// tb/tb_song_slot_recorder.sv - directed self-checking bench for song_slot_recorder
module tb_song_slot_recorder;

  logic        clk;
  logic        rst;
  logic [1:0]  slot_sel;
  logic [31:0] interval;
  logic        rec_start, rec_stop, play_start, play_stop, loop_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        out_valid, rec_busy, play_busy, full, done;
  logic [3:0]  slot_len;

  int checks = 0;
  int errors = 0;

  song_slot_recorder #(
    .DATA_W (8),
    .DEPTH  (8),
    .SLOTS  (4),
    .CNT_W  (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .slot_sel   (slot_sel),
    .interval   (interval),
    .rec_start  (rec_start),
    .rec_stop   (rec_stop),
    .play_start (play_start),
    .play_stop  (play_stop),
    .loop_en    (loop_en),
    .data_in    (data_in),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .rec_busy   (rec_busy),
    .play_busy  (play_busy),
    .full       (full),
    .done       (done),
    .slot_len   (slot_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick_clk;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; slot_sel = 2'd0; interval = 32'd1; data_in = 8'h00;
    rec_start = 1'b0; rec_stop = 1'b0; play_start = 1'b0; play_stop = 1'b0; loop_en = 1'b0;
    tick_clk(); tick_clk(); tick_clk();
    rst = 1'b0;
    checks++; if ({rec_busy, play_busy, out_valid, full, done} !== 5'b0) begin errors++;
      $display("FAIL reset_flags: got %b expected 00000", {rec_busy, play_busy, out_valid, full, done}); end
    checks++; if (data_out !== 8'h00) begin errors++;
      $display("FAIL reset_data_out: got %h expected 00", data_out); end
    checks++; if (slot_len !== 4'd0) begin errors++;
      $display("FAIL reset_slot_len: got %0d expected 0", slot_len); end
  endtask

  task automatic test_record;
    int dones;
    dones = 0;
    slot_sel = 2'd1; interval = 32'd3; rec_start = 1'b1;
    tick_clk();
    rec_start = 1'b0;
    checks++; if (rec_busy !== 1'b1) begin errors++;
      $display("FAIL rec_entry_busy: got %b expected 1", rec_busy); end
    for (int c = 1; c <= 15; c++) begin
      data_in  = 8'h10 + 8'((c + 2) / 3);
      rec_stop = (c == 15);
      if (done === 1'b1) dones++;
      tick_clk();
    end
    rec_stop = 1'b0;
    checks++; if (dones !== 0) begin errors++;
      $display("FAIL rec_early_done: got %0d expected 0", dones); end
    checks++; if ({rec_busy, done} !== 2'b01) begin errors++;
      $display("FAIL rec_stop_done: got busy,done=%b expected 01", {rec_busy, done}); end
    checks++; if (slot_len !== 4'd5) begin errors++;
      $display("FAIL rec_len: got %0d expected 5", slot_len); end
    tick_clk();
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL rec_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_play;
    logic [7:0] exp;
    slot_sel = 2'd1; interval = 32'd3; loop_en = 1'b0; play_start = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL play_pre_valid: got %b expected 0", out_valid); end
    tick_clk();
    play_start = 1'b0;
    interval = 32'd9;
    for (int c = 1; c <= 15; c++) begin
      exp = 8'h10 + 8'((c + 2) / 3);
      checks++; if ({play_busy, out_valid} !== 2'b11 || data_out !== exp) begin errors++;
        $display("FAIL play_seq c=%0d: got busy,valid=%b data=%h expected 11 data=%h",
                 c, {play_busy, out_valid}, data_out, exp); end
      tick_clk();
    end
    checks++; if ({play_busy, out_valid, done} !== 3'b001) begin errors++;
      $display("FAIL play_end: got busy,valid,done=%b expected 001", {play_busy, out_valid, done}); end
    tick_clk();
  endtask

  task automatic test_full;
    slot_sel = 2'd0; interval = 32'd1; rec_start = 1'b1;
    tick_clk();
    rec_start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      data_in = 8'hA0 + 8'(c);
      if (c <= 8) begin
        checks++; if ({rec_busy, done, full} !== 3'b100) begin errors++;
          $display("FAIL full_rec c=%0d: got busy,done,full=%b expected 100", c, {rec_busy, done, full}); end
      end else if (c == 9) begin
        checks++; if ({rec_busy, done, full} !== 3'b011) begin errors++;
          $display("FAIL full_hit: got busy,done,full=%b expected 011", {rec_busy, done, full}); end
      end else begin
        checks++; if ({rec_busy, done, full} !== 3'b001) begin errors++;
          $display("FAIL full_sticky: got busy,done,full=%b expected 001", {rec_busy, done, full}); end
      end
      tick_clk();
    end
    checks++; if (slot_len !== 4'd8) begin errors++;
      $display("FAIL full_len: got %0d expected 8", slot_len); end
  endtask

  task automatic test_empty;
    int pb;
    pb = 0;
    slot_sel = 2'd2; interval = 32'd1; play_start = 1'b1;
    tick_clk();
    play_start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (play_busy === 1'b1) pb++;
      checks++; if ({done, out_valid} !== ((c == 1) ? 2'b10 : 2'b00)) begin errors++;
        $display("FAIL empty_play c=%0d: got done,valid=%b expected %b", c, {done, out_valid},
                 (c == 1) ? 2'b10 : 2'b00); end
      tick_clk();
    end
    checks++; if (pb !== 0) begin errors++;
      $display("FAIL empty_busy: got %0d busy cycles expected 0", pb); end
  endtask

  task automatic test_loop;
    logic [7:0] exp;
    checks++; if (full !== 1'b1) begin errors++;
      $display("FAIL loop_full_before: got %b expected 1", full); end
    slot_sel = 2'd3; interval = 32'd2; rec_start = 1'b1;
    tick_clk();
    rec_start = 1'b0;
    checks++; if (full !== 1'b0) begin errors++;
      $display("FAIL loop_full_cleared: got %b expected 0", full); end
    for (int c = 1; c <= 6; c++) begin
      data_in  = 8'h30 + 8'((c + 1) / 2);
      rec_stop = (c == 6);
      tick_clk();
    end
    rec_stop = 1'b0;
    checks++; if (slot_len !== 4'd3) begin errors++;
      $display("FAIL loop_len: got %0d expected 3", slot_len); end
    tick_clk();
    loop_en = 1'b1; play_start = 1'b1;
    tick_clk();
    play_start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      exp = 8'h31 + 8'(((c - 1) / 2) % 3);
      checks++; if (out_valid !== 1'b1 || data_out !== exp) begin errors++;
        $display("FAIL loop_seq c=%0d: got valid=%b data=%h expected 1 data=%h", c, out_valid, data_out, exp); end
      play_stop = (c == 15);
      tick_clk();
    end
    play_stop = 1'b0; loop_en = 1'b0;
    checks++; if ({play_busy, out_valid, done} !== 3'b001) begin errors++;
      $display("FAIL loop_stop: got busy,valid,done=%b expected 001", {play_busy, out_valid, done}); end
    tick_clk();
  endtask

  task automatic test_misc;
    slot_sel = 2'd2; interval = 32'd1; data_in = 8'h77; rec_start = 1'b1;
    tick_clk();
    rec_start = 1'b0;
    tick_clk(); tick_clk(); tick_clk();
    checks++; if (slot_len !== 4'd3) begin errors++;
      $display("FAIL mid_rec_len: got %0d expected 3", slot_len); end
    rst = 1'b1;
    tick_clk();
    rst = 1'b0;
    checks++; if ({rec_busy, done, slot_len} !== 6'b0) begin errors++;
      $display("FAIL mid_rst_slot2: got busy,done,len=%b expected 000000", {rec_busy, done, slot_len}); end
    slot_sel = 2'd1; #1;
    checks++; if (slot_len !== 4'd0) begin errors++;
      $display("FAIL mid_rst_slot1: got %0d expected 0", slot_len); end
    slot_sel = 2'd0; interval = 32'd0; data_in = 8'h51; rec_start = 1'b1; play_start = 1'b1;
    tick_clk();
    rec_start = 1'b0; play_start = 1'b0;
    checks++; if ({rec_busy, play_busy} !== 2'b10) begin errors++;
      $display("FAIL rec_wins: got rec,play=%b expected 10", {rec_busy, play_busy}); end
    for (int c = 1; c <= 3; c++) begin
      data_in  = 8'h50 + 8'(c);
      rec_stop = (c == 3);
      tick_clk();
    end
    rec_stop = 1'b0;
    checks++; if (slot_len !== 4'd3) begin errors++;
      $display("FAIL intv0_rec_len: got %0d expected 3", slot_len); end
    tick_clk();
    play_start = 1'b1;
    tick_clk();
    play_start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++; if (out_valid !== 1'b1 || data_out !== (8'h50 + 8'(c))) begin errors++;
        $display("FAIL intv0_play c=%0d: got valid=%b data=%h expected 1 data=%h",
                 c, out_valid, data_out, 8'h50 + 8'(c)); end
      tick_clk();
    end
    checks++; if ({play_busy, out_valid, done} !== 3'b001) begin errors++;
      $display("FAIL intv0_end: got busy,valid,done=%b expected 001", {play_busy, out_valid, done}); end
  endtask

  initial begin
    test_reset();
    test_record();
    test_play();
    test_full();
    test_empty();
    test_loop();
    test_misc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
